// File: rtl/disp_pkg.sv
// Shared constants, FSM state type and digit-code helper for the scan_digits display front end.
package disp_pkg;

   localparam logic [4:0] BLANK_CODE = 5'd16;
   localparam int         DISP_MAX   = 9999;
   localparam int         NDIG       = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // A non-units digit is blanked when it and every more significant digit are zero.
   function automatic logic [4:0] digit_code(input logic [15:0] digs,
                                             input logic [1:0]  pos,
                                             input logic        blank_lz);
      logic upper_nz;
      upper_nz = 1'b0;
      for (int j = 0; j < NDIG; j++) begin
         if ((j >= int'(pos)) && (digs[4*j +: 4] != 4'd0)) upper_nz = 1'b1;
      end
      if (blank_lz && (pos != 2'd0) && !upper_nz) return BLANK_CODE;
      return {1'b0, digs[4*pos +: 4]};
   endfunction

endpackage

// File: rtl/scan_digits_if.sv
// Display-side bundle: load/value request, busy status, decoder code and anode enables.
interface scan_digits_if
   import disp_pkg::*;
#(
   parameter int VAL_W = 14
);
   // load is a request that is taken only while busy is low; a load seen while busy is high is dropped, never queued.
   logic [VAL_W-1:0] value;
   logic             load;
   logic             blank_lz;
   logic             busy;
   logic [4:0]       num;
   logic [3:0]       an;
   state_t           dbg_state;

   modport master (
      output value, load, blank_lz,
      input  busy, num, an, dbg_state
   );

   modport slave (
      input  value, load, blank_lz,
      output busy, num, an, dbg_state
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle, then a one-cycle COMMIT.
module bin2bcd_seq
   import disp_pkg::*;
#(
   parameter int VAL_W = 14
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [VAL_W-1:0] value_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [15:0]      bcd_o,
   output state_t           state_o
);

   localparam int CNT_W = $clog2(VAL_W + 1);

   state_t           state_q, state_d;
   logic [VAL_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      bcd_adj;
   logic [VAL_W-1:0] sat_val;

   always_comb begin
      sat_val = value_i;
      if (32'(value_i) > 32'(DISP_MAX)) sat_val = VAL_W'(DISP_MAX);
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int n = 0; n < NDIG; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               bin_d   = sat_val;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = {bcd_adj[14:0], bin_q[VAL_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(VAL_W - 1)) state_d = COMMIT;
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o  = (state_q != IDLE);
   assign done_o  = (state_q == COMMIT);
   assign bcd_o   = bcd_q;
   assign state_o = state_q;

endmodule

// File: rtl/scan_digits.sv
// Four-digit display front end: BCD conversion, digit registers and time-multiplexed decoder drive.
module scan_digits
   import disp_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int VAL_W    = 14
) (
   input  logic         CLK,
   input  logic         RST_N,
   scan_digits_if.slave disp_if
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d, idx_next;
   logic [15:0]      dig_q, dig_d;
   logic [3:0]       an_q, an_d;
   logic [4:0]       num_q, num_d;
   logic             wrap;
   logic             start;
   logic             done;
   logic             busy;
   logic [15:0]      bcd;
   state_t           state;

   assign start = disp_if.load && (state == IDLE);

   bin2bcd_seq #(
      .VAL_W (VAL_W)
   ) u_conv (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .start_i (start),
      .value_i (disp_if.value),
      .busy_o  (busy),
      .done_o  (done),
      .bcd_o   (bcd),
      .state_o (state)
   );

   assign wrap     = (div_q == DIV_W'(SCAN_DIV - 1));
   assign idx_next = idx_q + 2'd1;

   // A commit and a wrap on the same edge both resolve against the freshly committed digits.
   always_comb begin
      div_d = wrap ? '0 : div_q + 1'b1;
      idx_d = wrap ? idx_next : idx_q;
      dig_d = done ? bcd : dig_q;
      an_d  = an_q;
      num_d = num_q;
      if (wrap) begin
         an_d  = ~(4'b0001 << idx_next);
         num_d = digit_code(dig_d, idx_next, disp_if.blank_lz);
      end else if (done) begin
         num_d = digit_code(dig_d, idx_q, disp_if.blank_lz);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_q <= '0;
         idx_q <= '0;
         dig_q <= '0;
         an_q  <= 4'b1110;
         num_q <= 5'd0;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         dig_q <= dig_d;
         an_q  <= an_d;
         num_q <= num_d;
      end
   end

   assign disp_if.busy      = busy;
   assign disp_if.num       = num_q;
   assign disp_if.an        = an_q;
   assign disp_if.dbg_state = state;

endmodule
